// File: rtl/vga_cfg_sequencer_pkg.sv
// Shared definitions for the VGA config sequencer: FSM encoding, default
// parameter values and the default boot table.
package vga_cfg_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_BOOT         = 3'd1,
    ST_READY        = 3'd2,
    ST_HOST_WAIT_VS = 3'd3,
    ST_HOST_ISSUE   = 3'd4,
    ST_ERROR        = 3'd5
  } state_t;

  localparam int unsigned CFG_WIDTH_DEF    = 4;
  localparam int unsigned BOOT_ENTRIES_DEF = 8;
  localparam int unsigned TIMEOUT_DEF      = 64;

  // Boot data per table position; the address of entry i is simply i.
  function automatic logic [7:0] boot_data(input int unsigned idx);
    logic [7:0] d;
    case (idx)
      32'd0:   d = 8'h03;
      32'd1:   d = 8'h09;
      32'd2:   d = 8'h01;
      32'd3:   d = 8'h0C;
      32'd4:   d = 8'h05;
      32'd5:   d = 8'h0A;
      32'd6:   d = 8'h07;
      32'd7:   d = 8'h0E;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vga_cfg_sequencer_rom.sv
// Combinational boot-table lookup: table index -> {config addr, config data}.
module vga_cfg_sequencer_rom
  import vga_cfg_sequencer_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = CFG_WIDTH_DEF,
  parameter int unsigned IDX_W        = 3
) (
  input  logic [IDX_W-1:0]        idx_i,
  output logic [CONFIG_WIDTH-1:0] addr_o,
  output logic [CONFIG_WIDTH-1:0] data_o
);

  // Address equals the table position; data comes from the shared table.
  always_comb begin
    addr_o = CONFIG_WIDTH'(idx_i);
    data_o = CONFIG_WIDTH'(boot_data(32'(idx_i)));
  end

endmodule

// File: rtl/vga_cfg_sequencer.sv
// Owns the VGA controller config port: replays the boot table on start, then
// forwards single host writes, optionally deferred to the VSync onset.
//
//  state           | meaning
//  ----------------+--------------------------------------------------------
//  ST_IDLE         | after reset, waits for start
//  ST_BOOT         | streaming boot table entries to the controller
//  ST_READY        | boot done, accepting one host write
//  ST_HOST_WAIT_VS | host write held until VSync turns active
//  ST_HOST_ISSUE   | presenting the held host write to the controller
//  ST_ERROR        | handshake timed out, waits for start
module vga_cfg_sequencer
  import vga_cfg_sequencer_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = CFG_WIDTH_DEF,
  parameter int unsigned BOOT_ENTRIES = BOOT_ENTRIES_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
  parameter bit          SYNC_HOST    = 1'b1,
  parameter bit          VS_ACTIVE    = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    h_valid_i,
  input  logic [CONFIG_WIDTH-1:0] h_addr_i,
  input  logic [CONFIG_WIDTH-1:0] h_data_i,
  output logic                    h_rdy_o,
  input  logic                    vsync_i,
  output logic                    c_valid_o,
  output logic [CONFIG_WIDTH-1:0] c_addr_o,
  output logic [CONFIG_WIDTH-1:0] c_data_o,
  input  logic                    c_rdy_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int unsigned IDX_W = (BOOT_ENTRIES > 1) ? $clog2(BOOT_ENTRIES) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BOOT_ENTRIES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [CONFIG_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [CONFIG_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                    vs_q;
  logic                    c_valid_q, c_valid_d;
  logic [CONFIG_WIDTH-1:0] c_addr_q, c_addr_d;
  logic [CONFIG_WIDTH-1:0] c_data_q, c_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [IDX_W-1:0]        rom_idx;
  logic [CONFIG_WIDTH-1:0] rom_addr;
  logic [CONFIG_WIDTH-1:0] rom_data;

  logic xfer;
  logic stall;
  logic timed_out;
  logic vs_rise;

  vga_cfg_sequencer_rom #(
    .CONFIG_WIDTH (CONFIG_WIDTH),
    .IDX_W        (IDX_W)
  ) u_rom (
    .idx_i  (rom_idx),
    .addr_o (rom_addr),
    .data_o (rom_data)
  );

  assign xfer      = c_valid_q & c_rdy_i;
  assign stall     = c_valid_q & ~c_rdy_i;
  assign timed_out = stall && (timer_q == TMR_LAST);
  // Only a transition into the active level counts, never a level already held.
  assign vs_rise   = (vsync_i == VS_ACTIVE) && (vs_q != VS_ACTIVE);

  // Next-state, next-output and datapath selection for the sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    c_valid_d   = c_valid_q;
    c_addr_d    = c_addr_q;
    c_data_d    = c_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    rom_idx     = '0;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start_i) begin
          state_d   = ST_BOOT;
          idx_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          c_valid_d = 1'b1;
          c_addr_d  = rom_addr;
          c_data_d  = rom_data;
        end
      end

      ST_BOOT: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d   = ST_READY;
            c_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            idx_d     = idx_q + 1'b1;
            rom_idx   = idx_q + 1'b1;
            c_addr_d  = rom_addr;
            c_data_d  = rom_data;
          end
        end else if (timed_out) begin
          state_d   = ST_ERROR;
          c_valid_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
        end
      end

      ST_READY: begin
        if (start_i) begin
          state_d   = ST_BOOT;
          idx_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          c_valid_d = 1'b1;
          c_addr_d  = rom_addr;
          c_data_d  = rom_data;
        end else if (h_valid_i) begin
          hold_addr_d = h_addr_i;
          hold_data_d = h_data_i;
          if (SYNC_HOST) begin
            state_d = ST_HOST_WAIT_VS;
          end else begin
            state_d   = ST_HOST_ISSUE;
            c_valid_d = 1'b1;
            c_addr_d  = h_addr_i;
            c_data_d  = h_data_i;
          end
        end
      end

      ST_HOST_WAIT_VS: begin
        if (vs_rise) begin
          state_d   = ST_HOST_ISSUE;
          c_valid_d = 1'b1;
          c_addr_d  = hold_addr_q;
          c_data_d  = hold_data_q;
        end
      end

      ST_HOST_ISSUE: begin
        if (xfer) begin
          state_d   = ST_READY;
          c_valid_d = 1'b0;
        end else if (timed_out) begin
          state_d   = ST_ERROR;
          c_valid_d = 1'b0;
          err_d     = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        c_valid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase

    // Timer measures one uninterrupted stall; any progress restarts it.
    if (xfer || (state_d != state_q)) begin
      timer_d = '0;
    end else if (stall) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end
  end

  // State, counters, hold registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      vs_q        <= 1'b0;
      c_valid_q   <= 1'b0;
      c_addr_q    <= '0;
      c_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      vs_q        <= vsync_i;
      c_valid_q   <= c_valid_d;
      c_addr_q    <= c_addr_d;
      c_data_q    <= c_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // A start pulse in READY takes priority, so the host is not told it was accepted.
  assign h_rdy_o   = (state_q == ST_READY) & ~start_i;
  assign c_valid_o = c_valid_q;
  assign c_addr_o  = c_addr_q;
  assign c_data_o  = c_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_vga_cfg_sequencer.sv
// Self-checking bench for vga_cfg_sequencer with a transaction-level model of
// the boot table, host write deferral and handshake timeout.
module tb_vga_cfg_sequencer;

  localparam int CW       = 4;
  localparam int NENT     = 8;
  localparam int TMO      = 64;
  localparam bit VS_ACT   = 1'b0;
  localparam logic [3:0] EXP_DATA [NENT] = '{4'h3, 4'h9, 4'h1, 4'hC, 4'h5, 4'hA, 4'h7, 4'hE};

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          h_valid_i = 1'b0;
  logic [CW-1:0] h_addr_i = '0;
  logic [CW-1:0] h_data_i = '0;
  logic          h_rdy_o;
  logic          vsync_i = VS_ACT;
  logic          c_valid_o;
  logic [CW-1:0] c_addr_o;
  logic [CW-1:0] c_data_o;
  logic          c_rdy_i = 1'b1;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  bit         stab_en = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] word_prev = '0;

  vga_cfg_sequencer #(
    .CONFIG_WIDTH (CW),
    .BOOT_ENTRIES (NENT),
    .TIMEOUT      (TMO),
    .SYNC_HOST    (1'b1),
    .VS_ACTIVE    (VS_ACT)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .h_valid_i (h_valid_i),
    .h_addr_i  (h_addr_i),
    .h_data_i  (h_data_i),
    .h_rdy_o   (h_rdy_o),
    .vsync_i   (vsync_i),
    .c_valid_o (c_valid_o),
    .c_addr_o  (c_addr_o),
    .c_data_o  (c_data_o),
    .c_rdy_i   (c_rdy_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transfer log plus the hold-while-stalled rule, seen just before each edge.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (stab_en && stall_prev)
        check_eq("stall_hold", {c_valid_o, c_addr_o, c_data_o}, {1'b1, word_prev});
      if (c_valid_o && c_rdy_i) got_q.push_back({c_addr_o, c_data_o});
      stall_prev = c_valid_o && !c_rdy_i;
      word_prev  = {c_addr_o, c_data_o};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic check_boot_log(input string tag);
    check_eq({tag, "_len"}, got_q.size(), NENT);
    for (int i = 0; i < NENT && i < got_q.size(); i++)
      check_eq({tag, "_entry"}, got_q[i], {i[3:0], EXP_DATA[i]});
  endtask

  // mode 0: C_rdy always 1; mode 1: C_rdy high one cycle in three.
  task automatic do_boot(input string tag, input int mode, input bit with_host);
    int busy_n;
    int done_at;
    got_q.delete();
    @(negedge clk_i);
    start_i = 1'b1;
    c_rdy_i = (mode == 0);
    if (with_host) begin
      h_valid_i = 1'b1;
      h_addr_i  = 4'h5;
      h_data_i  = 4'h9;
      #1;
      check_eq({tag, "_hrdy_start"}, h_rdy_o, 1'b0);
    end
    busy_n  = 0;
    done_at = -1;
    stab_en = (mode == 1);
    for (int i = 0; i < 300 && done_at < 0; i++) begin
      @(negedge clk_i);
      start_i   = 1'b0;
      h_valid_i = 1'b0;
      if (i == 0) begin
        check_eq({tag, "_cvalid0"}, c_valid_o, 1'b1);
        check_eq({tag, "_first"}, {c_addr_o, c_data_o}, {4'h0, EXP_DATA[0]});
        check_eq({tag, "_done_clr"}, done_o, 1'b0);
        check_eq({tag, "_err_clr"}, err_o, 1'b0);
      end
      if (busy_o) busy_n++;
      if (done_o) done_at = i;
      else c_rdy_i = (mode == 0) ? 1'b1 : ((i % 3) == 2);
    end
    stab_en = 1'b0;
    c_rdy_i = 1'b1;
    check_eq({tag, "_done_seen"}, done_at >= 0, 1'b1);
    if (mode == 0) begin
      check_eq({tag, "_done_cycle"}, done_at, NENT);
      check_eq({tag, "_busy_cycles"}, busy_n, NENT);
    end
    check_eq({tag, "_cvalid_end"}, c_valid_o, 1'b0);
    check_eq({tag, "_busy_end"}, busy_o, 1'b0);
    check_eq({tag, "_hrdy_end"}, h_rdy_o, 1'b1);
    check_boot_log(tag);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cv_n;
    int err_at;
    bit es;
    bit fin;
    logic pv;
    logic [3:0] ra, rd;

    // Reset values
    repeat (2) @(negedge clk_i);
    check_eq("rst_cvalid", c_valid_o, 1'b0);
    check_eq("rst_outs", {busy_o, done_o, err_o, h_rdy_o}, 4'b0000);
    check_eq("rst_cword", {c_addr_o, c_data_o}, 8'h00);
    rst_ni = 1'b1;

    // IDLE ignores host requests
    @(negedge clk_i);
    h_valid_i = 1'b1; h_addr_i = 4'h1; h_data_i = 4'h1;
    repeat (3) begin
      @(negedge clk_i);
      check_eq("idle_hrdy", h_rdy_o, 1'b0);
      check_eq("idle_cvalid", c_valid_o, 1'b0);
    end
    h_valid_i = 1'b0;

    do_boot("boot_fast", 0, 1'b0);
    do_boot("boot_stall", 1, 1'b0);

    // Deferred host write: active VSync at entry must not trigger it
    vsync_i = VS_ACT;
    c_rdy_i = 1'b1;
    got_q.delete();
    @(negedge clk_i);
    h_valid_i = 1'b1; h_addr_i = 4'hB; h_data_i = 4'h2;
    #1 check_eq("host_hrdy", h_rdy_o, 1'b1);
    @(negedge clk_i);
    h_valid_i = 1'b0;
    check_eq("host_hrdy_drop", h_rdy_o, 1'b0);
    repeat (4) begin
      @(negedge clk_i);
      check_eq("host_wait_act", c_valid_o, 1'b0);
    end
    vsync_i = ~VS_ACT;
    repeat (3) begin
      @(negedge clk_i);
      check_eq("host_wait_inact", c_valid_o, 1'b0);
    end
    vsync_i = VS_ACT;
    @(negedge clk_i);
    check_eq("host_issue", {c_valid_o, c_addr_o, c_data_o}, {1'b1, 4'hB, 4'h2});
    @(negedge clk_i);
    check_eq("host_back_ready", {c_valid_o, h_rdy_o}, 2'b01);
    check_eq("host_log_len", got_q.size(), 1);
    if (got_q.size() > 0) check_eq("host_log", got_q[0], 8'hB2);

    // Start wins over a simultaneous host request
    do_boot("start_hv", 0, 1'b1);

    // Randomised host writes against the deferral model
    for (int w = 0; w < 24; w++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
      @(negedge clk_i);
      ra = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 15));
      h_valid_i = 1'b1; h_addr_i = ra; h_data_i = rd;
      c_rdy_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) vsync_i = ~vsync_i;
      pv = vsync_i;
      #1 check_eq("rnd_hrdy", h_rdy_o, 1'b1);
      es = 1'b0;
      fin = 1'b0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
        @(negedge clk_i);
        h_valid_i = 1'b0;
        check_eq("rnd_cvalid", c_valid_o, es);
        if (c_valid_o) check_eq("rnd_word", {c_addr_o, c_data_o}, {ra, rd});
        c_rdy_i = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) vsync_i = ~vsync_i;
        if (es && c_valid_o && c_rdy_i) fin = 1'b1;
        else if (!es && vsync_i == VS_ACT && pv != VS_ACT) es = 1'b1;
        pv = vsync_i;
      end
      check_eq("rnd_complete", fin, 1'b1);
      @(negedge clk_i);
      check_eq("rnd_ready", {c_valid_o, h_rdy_o}, 2'b01);
    end

    // Timeout with C_rdy stuck low, then recovery
    @(negedge clk_i);
    start_i = 1'b1;
    c_rdy_i = 1'b0;
    cv_n = 0;
    err_at = -1;
    for (int i = 0; i < 200 && err_at < 0; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (err_o) err_at = i;
      else if (c_valid_o) cv_n++;
    end
    check_eq("tmo_err_seen", err_at >= 0, 1'b1);
    check_eq("tmo_cvalid_cycles", cv_n, TMO);
    check_eq("tmo_outs", {c_valid_o, busy_o, h_rdy_o}, 3'b000);
    @(negedge clk_i);
    check_eq("tmo_err_sticky", err_o, 1'b1);
    c_rdy_i = 1'b1;
    do_boot("tmo_recover", 0, 1'b0);

    // Asynchronous reset in the middle of a stalled boot
    @(negedge clk_i);
    start_i = 1'b1;
    c_rdy_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("mid_rst_before", {c_valid_o, busy_o}, 2'b11);
    #2 rst_ni = 1'b0;
    #1 check_eq("mid_rst_async", {c_valid_o, busy_o}, 2'b00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    c_rdy_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      check_eq("post_rst_idle", {c_valid_o, busy_o, done_o, h_rdy_o}, 4'b0000);
    end
    do_boot("post_rst_boot", 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
